// File: rtl/inst_fetch_stage.sv
// PC generator and IF/ID pipeline register feeding a zero-latency instruction ROM.
// Optional accepted-fetch counter is built only when IF_FETCH_COUNT_EN is defined.
module inst_fetch_stage #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned PC_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_branchEnable,
  input  logic [ADDR_WIDTH-1:0] i_branchTarget,
  input  logic                  i_halt,
  input  logic [INST_WIDTH-1:0] i_romInst,
  output logic                  o_romEnable,
  output logic [ADDR_WIDTH-1:0] o_romAddr,
  output logic [ADDR_WIDTH-1:0] o_idPc,
  output logic [INST_WIDTH-1:0] o_idInst,
  output logic                  o_idValid,
  output logic [31:0]           o_fetchCount
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;
  logic                  id_valid_q, id_valid_d;
  logic                  load_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  // State transitions are independent of branch/stall priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (i_halt) state_d = S_HALT;
      S_HALT:  if (!i_halt) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    load_valid = 1'b0;
    if (i_branchEnable) begin
      pc_d       = {i_branchTarget[ADDR_WIDTH-1:2], 2'b00};
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else if (i_stall) begin
      pc_d = pc_q;
    end else if (state_q == S_RUN && !i_halt) begin
      id_pc_d    = pc_q;
      id_inst_d  = i_romInst;
      id_valid_d = 1'b1;
      load_valid = 1'b1;
      pc_d       = pc_q + ADDR_WIDTH'(PC_STEP);
    end else begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end
  end

  assign o_romEnable = (state_q == S_RUN);
  assign o_romAddr   = pc_q;
  assign o_idPc      = id_pc_q;
  assign o_idInst    = id_inst_q;
  assign o_idValid   = id_valid_q;

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
    end else if (load_valid) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign o_fetchCount = fetch_cnt_q;
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
  assign o_fetchCount      = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Randomized self-checking bench for inst_fetch_stage against a behavioural fetch model.
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        halt = 1'b0;
  logic [31:0] rom_inst;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] fetch_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: fetch address, boot/halt flags, expected IF/ID contents and fetch count.
  logic [31:0] m_pc;
  bit          m_booted;
  bit          m_halted;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  bit          m_id_valid;
  logic [31:0] m_cnt;

  inst_fetch_stage #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .RESET_PC  (32'h0),
    .PC_STEP   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (stall),
    .i_branchEnable(br_en),
    .i_branchTarget(br_tgt),
    .i_halt        (halt),
    .i_romInst     (rom_inst),
    .o_romEnable   (rom_en),
    .o_romAddr     (rom_addr),
    .o_idPc        (id_pc),
    .o_idInst      (id_inst),
    .o_idValid     (id_valid),
    .o_fetchCount  (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  assign rom_inst = rom_f(rom_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_cnt;
`ifdef IF_FETCH_COUNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'h0;
`endif
    check_eq("romAddr",    rom_addr, m_pc);
    check_eq("romEnable",  {31'h0, rom_en}, {31'h0, m_booted && !m_halted});
    check_eq("idPc",       id_pc, m_id_pc);
    check_eq("idInst",     id_inst, m_id_inst);
    check_eq("idValid",    {31'h0, id_valid}, {31'h0, m_id_valid});
    check_eq("fetchCount", fetch_cnt, exp_cnt);
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_booted   = 1'b0;
    m_halted   = 1'b0;
    m_id_pc    = 32'h0;
    m_id_inst  = 32'h0;
    m_id_valid = 1'b0;
    m_cnt      = 32'h0;
  endtask

  // Asserts reset asynchronously (inputs left as they are), checks at once, then releases.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_romEnable", {31'h0, rom_en}, 32'h0);
    check_eq("rst_idValid",   {31'h0, id_valid}, 32'h0);
    check_all();
    @(posedge clk);
    #1;
    stall = 1'b0; br_en = 1'b0; halt = 1'b0; br_tgt = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all();
  endtask

  task automatic step(input bit st, input bit br, input bit hl, input logic [31:0] tgt);
    logic [31:0] inst_now;
    bit          fetching;
    stall = st; br_en = br; halt = hl; br_tgt = tgt;
    inst_now = rom_f(m_pc);
    fetching = m_booted && !m_halted && !hl;
    @(posedge clk);
    if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (fetching) begin
      m_id_pc = m_pc; m_id_inst = inst_now; m_id_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
    end
    if (!m_booted) begin
      m_booted = 1'b1;
      m_halted = 1'b0;
    end else begin
      m_halted = hl;
    end
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    // Boot bubble, then sequential fetch from 0
    repeat (3) step(0, 0, 0, '0);
    check_eq("seq_idPc", id_pc, 32'h4);
    check_eq("seq_idInst", id_inst, 32'h101);
    // Stall three cycles with romAddr at 8
    repeat (3) step(1, 0, 0, '0);
    check_eq("stall_romAddr", rom_addr, 32'h8);
    step(0, 0, 0, '0);
    check_eq("post_stall_idPc", id_pc, 32'h8);
    // Branch at pc 0xC to 0x41
    step(0, 1, 0, 32'h41);
    check_eq("br_romAddr", rom_addr, 32'h40);
    step(0, 0, 0, '0);
    check_eq("br_idPc", id_pc, 32'h40);
    // Branch and stall together
    step(1, 1, 0, 32'h80);
    check_eq("brstall_romAddr", rom_addr, 32'h80);
    // Halt two cycles, branch while halted, resume
    step(0, 1, 0, 32'h10);
    repeat (2) step(0, 0, 1, '0);
    step(0, 1, 1, 32'h20);
    repeat (3) step(0, 0, 0, '0);
    // Wrap from 0xFFFFFFFC to 0
    step(0, 1, 0, 32'hFFFF_FFFE);
    repeat (3) step(0, 0, 0, '0);
    // Reset while stall and halt are held high
    stall = 1'b1; halt = 1'b1;
    do_reset();
    repeat (3) step(0, 0, 0, '0);

    for (int i = 0; i < 600; i++) begin
      bit          st, br, hl;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 99) < 20);
      br  = ($urandom_range(0, 99) < 10);
      hl  = ($urandom_range(0, 99) < 15);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      if ($urandom_range(0, 199) == 0) begin
        stall = st; halt = hl;
        do_reset();
      end else begin
        step(st, br, hl, tgt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
